// File: rtl/sha256_msg_padder_if.sv
// Stream interface of the SHA-256 message padder: 32-bit message words in, 512-bit chunks out.
interface sha256_msg_padder_if;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic [1:0]   in_bytes;
  logic         in_ready;
  logic [511:0] chunk_out;
  logic         chunk_valid;
  logic         chunk_ready;
  logic         chunk_first;
  logic         chunk_last;

  modport master (
    output in_data, in_valid, in_last, in_bytes, chunk_ready,
    input  in_ready, chunk_out, chunk_valid, chunk_first, chunk_last
  );

  modport slave (
    input  in_data, in_valid, in_last, in_bytes, chunk_ready,
    output in_ready, chunk_out, chunk_valid, chunk_first, chunk_last
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs big-endian words into 512-bit chunks, appends 0x80 marker and bit length.
// Optional build macro SHA256_PADDER_LEN64_EN widens the length counter from 32 to 64 bits.
module sha256_msg_padder (
  input logic                 clk,
  input logic                 rst,
  sha256_msg_padder_if.slave  bus
);

`ifdef SHA256_PADDER_LEN64_EN
  localparam int LEN_W = 64;
`else
  localparam int LEN_W = 32;
`endif

  typedef enum logic [2:0] {S_FILL, S_FULL, S_TAIL, S_SPILL, S_FINAL} state_t;

  state_t             state_q, state_d;
  logic [31:0]        wbuf_q [16];
  logic [31:0]        wbuf_d [16];
  logic [3:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   len_inc;
  logic               first_q, first_d;
  logic [1:0]         lbytes_q, lbytes_d;
  logic               mark_q, mark_d;
  logic [31:0]        len_hi, len_lo;
  logic [4:0]         p;
  logic               in_acc, chunk_hs;

  // Keep the leading b bytes, put the marker right after them and clear the rest.
  function automatic logic [31:0] pad_partial(input logic [31:0] w, input logic [1:0] b);
    case (b)
      2'd1:    return {w[31:24], 8'h80, 16'h0000};
      2'd2:    return {w[31:16], 8'h80, 8'h00};
      default: return {w[31:8], 8'h80};
    endcase
  endfunction

  assign bus.in_ready    = (state_q == S_FILL) && !rst;
  assign bus.chunk_valid = (state_q == S_FULL) || (state_q == S_SPILL) || (state_q == S_FINAL);
  assign bus.chunk_last  = (state_q == S_FINAL);
  assign bus.chunk_first = bus.chunk_valid && first_q;

  assign in_acc   = bus.in_valid && bus.in_ready;
  assign chunk_hs = bus.chunk_valid && bus.chunk_ready;

  always_comb begin
    for (int i = 0; i < 16; i++) bus.chunk_out[32*i +: 32] = wbuf_q[i];
  end

  always_comb begin
`ifdef SHA256_PADDER_LEN64_EN
    len_hi = len_q[63:32];
`else
    len_hi = 32'h0;
`endif
    len_lo  = len_q[31:0];
    len_inc = (bus.in_last && bus.in_bytes != 2'd0) ? LEN_W'({bus.in_bytes, 3'b000})
                                                    : LEN_W'(32);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    first_d  = first_q;
    lbytes_d = lbytes_q;
    mark_d   = mark_q;
    p        = 5'd0;
    for (int i = 0; i < 16; i++) wbuf_d[i] = wbuf_q[i];

    case (state_q)
      S_FILL: begin
        if (in_acc) begin
          wbuf_d[idx_q] = bus.in_data;
          len_d         = len_q + len_inc;
          if (bus.in_last) begin
            lbytes_d = bus.in_bytes;
            state_d  = S_TAIL;
          end else if (idx_q == 4'd15) begin
            state_d = S_FULL;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_FULL: begin
        if (chunk_hs) begin
          idx_d   = 4'd0;
          first_d = 1'b0;
          state_d = S_FILL;
        end
      end
      S_TAIL: begin
        // p is the marker word; 16 means the marker spills into the next chunk.
        p = (lbytes_q != 2'd0) ? {1'b0, idx_q} : {1'b0, idx_q} + 5'd1;
        for (int i = 0; i < 16; i++) begin
          if (5'(i) > p)
            wbuf_d[i] = 32'h0;
          else if (5'(i) == p)
            wbuf_d[i] = (lbytes_q != 2'd0) ? pad_partial(wbuf_q[i], lbytes_q) : 32'h8000_0000;
        end
        if (p <= 5'd13) begin
          wbuf_d[14] = len_hi;
          wbuf_d[15] = len_lo;
          state_d    = S_FINAL;
        end else begin
          mark_d  = (p == 5'd16);
          state_d = S_SPILL;
        end
      end
      S_SPILL: begin
        if (chunk_hs) begin
          for (int i = 0; i < 16; i++) wbuf_d[i] = 32'h0;
          wbuf_d[0]  = mark_q ? 32'h8000_0000 : 32'h0;
          wbuf_d[14] = len_hi;
          wbuf_d[15] = len_lo;
          first_d    = 1'b0;
          state_d    = S_FINAL;
        end
      end
      S_FINAL: begin
        if (chunk_hs) begin
          len_d   = '0;
          idx_d   = 4'd0;
          first_d = 1'b1;
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FILL;
      idx_q    <= 4'd0;
      len_q    <= '0;
      first_q  <= 1'b1;
      lbytes_q <= 2'd0;
      mark_q   <= 1'b0;
      for (int i = 0; i < 16; i++) wbuf_q[i] <= 32'h0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      first_q  <= first_d;
      lbytes_q <= lbytes_d;
      mark_q   <= mark_d;
      for (int i = 0; i < 16; i++) wbuf_q[i] <= wbuf_d[i];
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: hand-computed padded chunks for a set of message lengths.
module tb_sha256_msg_padder;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  sha256_msg_padder_if bus();

  sha256_msg_padder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk512(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] put(input logic [511:0] c, input int i, input logic [31:0] v);
    logic [511:0] r;
    r = c;
    r[32*i +: 32] = v;
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the word was accepted.
  task automatic send(input logic [31:0] d, input logic last, input logic [1:0] b);
    int t;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_bytes = b;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk1("send.in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic get_chunk(input string tag, input logic [511:0] ec, input logic ef, input logic el);
    int t;
    t = 0;
    while (!bus.chunk_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk1({tag, ".valid"}, bus.chunk_valid, 1'b1);
    chk512({tag, ".data"}, bus.chunk_out, ec);
    chk1({tag, ".first"}, bus.chunk_first, ef);
    chk1({tag, ".last"}, bus.chunk_last, el);
    chk1({tag, ".in_ready"}, bus.in_ready, 1'b0);
    bus.chunk_ready = 1'b1;
    @(negedge clk);
    bus.chunk_ready = 1'b0;
  endtask

  logic [511:0] abc_exp;

  task automatic run_abc(input string tag);
    send(32'h6162_6300, 1'b1, 2'd3);
    chk1({tag, ".tail_valid"}, bus.chunk_valid, 1'b0);
    @(negedge clk);
    chk1({tag, ".final_valid"}, bus.chunk_valid, 1'b1);
    get_chunk(tag, abc_exp, 1'b1, 1'b1);
  endtask

  initial begin
    logic [31:0]  pat [4];
    logic [511:0] e1, e2;

    pat[0] = 32'h6865_6c6f;
    pat[1] = 32'h7772_6c64;
    pat[2] = 32'h3132_3335;
    pat[3] = 32'h3433_3232;
    abc_exp = put(put('0, 0, 32'h6162_6380), 15, 32'h0000_0018);

    rst = 1'b1;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.in_bytes = 2'd0;
    bus.chunk_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk1("rst.in_ready", bus.in_ready, 1'b0);
    chk1("rst.chunk_valid", bus.chunk_valid, 1'b0);
    chk1("rst.chunk_first", bus.chunk_first, 1'b0);
    chk1("rst.chunk_last", bus.chunk_last, 1'b0);
    chk512("rst.chunk_out", bus.chunk_out, 512'h0);
    rst = 1'b0;
    @(negedge clk);
    chk1("post_rst.in_ready", bus.in_ready, 1'b1);

    // "abc": single chunk
    run_abc("abc");

    // 16 full words: marker and length spill into a second chunk
    e1 = '0;
    for (int i = 0; i < 16; i++) begin
      e1 = put(e1, i, pat[i % 4]);
      send(pat[i % 4], i == 15, 2'd0);
    end
    e2 = put(put('0, 0, 32'h8000_0000), 15, 32'h0000_0200);
    get_chunk("w16.c1", e1, 1'b1, 1'b0);
    get_chunk("w16.c2", e2, 1'b0, 1'b1);

    // 14 full words: marker at word 14, length alone in second chunk
    e1 = '0;
    for (int i = 0; i < 14; i++) begin
      e1 = put(e1, i, 32'h0A00_0000 + i);
      send(32'h0A00_0000 + i, i == 13, 2'd0);
    end
    e1 = put(e1, 14, 32'h8000_0000);
    e2 = put('0, 15, 32'h0000_01C0);
    get_chunk("w14.c1", e1, 1'b1, 1'b0);
    get_chunk("w14.c2", e2, 1'b0, 1'b1);

    // 13 full words: marker at word 13 still leaves room for the length
    e1 = '0;
    for (int i = 0; i < 13; i++) begin
      e1 = put(e1, i, 32'h0B00_0000 + i);
      send(32'h0B00_0000 + i, i == 12, 2'd0);
    end
    e1 = put(put(e1, 13, 32'h8000_0000), 15, 32'h0000_01A0);
    get_chunk("w13", e1, 1'b1, 1'b1);

    // Two words, last with one valid byte
    send(32'hAABB_CCDD, 1'b0, 2'd0);
    send(32'h1122_3344, 1'b1, 2'd1);
    e1 = put(put(put('0, 0, 32'hAABB_CCDD), 1, 32'h1180_0000), 15, 32'h0000_0028);
    get_chunk("b1", e1, 1'b1, 1'b1);

    // 15 words, last with two bytes: marker lands at word 14, forcing a spill without marker
    e1 = '0;
    for (int i = 0; i < 14; i++) begin
      e1 = put(e1, i, 32'h0C00_0000 + i);
      send(32'h0C00_0000 + i, 1'b0, 2'd0);
    end
    send(32'h1122_3344, 1'b1, 2'd2);
    e1 = put(e1, 14, 32'h1122_8000);
    e2 = put('0, 15, 32'h0000_01D0);
    get_chunk("b2.c1", e1, 1'b1, 1'b0);
    get_chunk("b2.c2", e2, 1'b0, 1'b1);

    // 20 words with the consumer stalling 5 cycles on the first chunk
    e1 = '0;
    for (int i = 0; i < 16; i++) begin
      e1 = put(e1, i, 32'h1000_0000 + i);
      send(32'h1000_0000 + i, 1'b0, 2'd0);
    end
    chk1("stall.valid_rise", bus.chunk_valid, 1'b1);
    bus.in_data  = 32'h1000_0010;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk512("stall.out", bus.chunk_out, e1);
      chk1("stall.valid", bus.chunk_valid, 1'b1);
      chk1("stall.in_ready", bus.in_ready, 1'b0);
      @(negedge clk);
    end
    get_chunk("stall.c1", e1, 1'b1, 1'b0);
    e2 = '0;
    for (int i = 16; i < 20; i++) begin
      e2 = put(e2, i - 16, 32'h1000_0000 + i);
      send(32'h1000_0000 + i, i == 19, 2'd0);
    end
    e2 = put(put(e2, 4, 32'h8000_0000), 15, 32'h0000_0280);
    get_chunk("stall.c2", e2, 1'b0, 1'b1);

    // Reset mid-message discards the partial message
    for (int i = 0; i < 7; i++) send(32'h2000_0000 + i, 1'b0, 2'd0);
    rst = 1'b1;
    @(negedge clk);
    chk1("midrst.in_ready", bus.in_ready, 1'b0);
    chk1("midrst.chunk_valid", bus.chunk_valid, 1'b0);
    chk512("midrst.chunk_out", bus.chunk_out, 512'h0);
    rst = 1'b0;
    @(negedge clk);
    run_abc("abc_after_rst");

`ifdef SHA256_PADDER_LEN64_EN
    // Length above 2^32 must show up in word 14
    force dut.len_q = 64'h1_0000_0000;
    #1 release dut.len_q;
    send(32'h6162_6300, 1'b1, 2'd3);
    e1 = put(put(put('0, 0, 32'h6162_6380), 14, 32'h0000_0001), 15, 32'h0000_0018);
    get_chunk("len64", e1, 1'b1, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Message-side front end for `sha256_512chunk`. Accepts a message as a stream of big-endian 32-bit words and emits the sequence of 512-bit chunks the compression core consumes. Applies standard SHA-256 padding: 0x80 marker, zero fill and bit-length trailer, adding an extra chunk when required. Chunk word i occupies `chunk_out[32*i+31:32*i]`, so word 0 is in the LSBs and the length trailer is in word 15 at `[511:480]`.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_data` in 32: message word; first byte is in `[31:24]`.
- `in_valid` in 1: `in_data` is valid.
- `in_last` in 1: final word of the message.
- `in_bytes` in 2: valid bytes in the final word (1–3; 0 means 4). Ignored unless `in_last` is high.
- `in_ready` out 1: word is accepted when `in_valid && in_ready`.
- `chunk_out` out 512: assembled chunk.
- `chunk_valid` out 1: `chunk_out` is valid.
- `chunk_ready` in 1: chunk is consumed when `chunk_valid && chunk_ready`.
- `chunk_first` out 1: chunk is the first of its message.
- `chunk_last` out 1: chunk is the final (length-bearing) chunk.

## Operation
- States:
  - FILL: `in_ready`=1.
  - FULL, SPILL, FINAL: `chunk_valid`=1.
  - TAIL: internal, one cycle.
- Registers:
  - 16×32 word buffer.
  - 4-bit word index `idx`.
  - 64-bit bit-length counter `len`.
  - `first` flag, set at reset and after each FINAL handshake.
- FILL, word accepted:
  - Write `buf[idx]`.
  - Add 32 to `len`, or 8×`in_bytes` for a partial last word.
  - Not last, `idx`=15: go to FULL.
  - Not last, `idx`<15: increment `idx`.
  - Last: go to TAIL.
- FULL: on handshake, go to FILL, set `idx`=0, clear `first`.
- TAIL:
  - Partial last word: replace byte `in_bytes` (counted from MSB) with 0x80 and zero the bytes below it. Marker position p = `idx`.
  - Full last word: marker word 0x80000000 goes at p = `idx`+1.
  - Zero all words above p.
  - If p ≤ 13: write `len[63:32]` to word 14 and `len[31:0]` to word 15, then go to FINAL.
  - Otherwise go to SPILL. If p = 16, word 0 of the next chunk carries the marker.
- SPILL: `chunk_last`=0. On handshake:
  - Load buffer with all zeros plus the length in words 14/15.
  - Word 0 = 0x80000000 if p = 16, else 0.
  - Clear `first`, go to FINAL.
- FINAL: `chunk_last`=1. On handshake:
  - Clear `len` and `idx`, set `first`.
  - Go to FILL.
- `chunk_first` reflects `first` while `chunk_valid` is high and is 0 otherwise.
- `chunk_out` is driven directly from the buffer. It is stable while `chunk_valid` is high and not handshaken.
- `len` wraps modulo 2^64, with no overflow flag.
- Zero-length messages are not supported.

## Timing
- Reset values:
  - State FILL, `idx`=0, `len`=0, `first`=1.
  - `chunk_valid`=0, `chunk_first`=0, `chunk_last`=0.
  - `chunk_out`=0 (buffer cleared).
  - `in_ready`=0 while `rst` is high; it is combinational from state and is 1 in the cycle after reset deasserts.
- Throughput: one word per cycle in FILL.
- `chunk_valid` rises the cycle after the 16th word is accepted.
- Last word to final chunk:
  - 2 cycles when p ≤ 13 (accept, TAIL, FINAL valid).
  - 1 extra chunk handshake otherwise.
- `chunk_valid` holds until `chunk_ready`, and drops or updates the cycle after the handshake.
- `in_ready` is 0 throughout FULL, TAIL, SPILL and FINAL. No input is accepted in the cycle a chunk handshake occurs.
- `rst` mid-message: discard the buffer and length. Outputs take reset values on the next edge, and the partial message is lost.

## Configuration
- `SHA256_PADDER_LEN64_EN` defined:
  - Full 64-bit `len`.
  - Word 14 carries `len[63:32]`.
- Not defined:
  - 32-bit `len`, wrapping at 2^32.
  - Word 14 is always 0.
  - Saves 32 flops and an adder slice.
- Chunk boundaries and marker placement are identical in both builds.

## Test plan
- 16 words, each 4-word group = 0x68656c6f, 0x77726c64, 0x31323335, 0x34333232; last with `in_bytes`=0 -> two chunks:
  - Chunk 1: the 16 words, `first`=1, `last`=0.
  - Chunk 2 = {32'h00000200, 448'h0, 32'h80000000}, `last`=1.
- "abc" (one word 0x61626300, `in_last`=1, `in_bytes`=3) -> single chunk with `first`=`last`=1:
  - Word 0 = 0x61626380.
  - Words 1–14 = 0.
  - Word 15 = 0x00000018.
- 14 full words -> two chunks:
  - Chunk 1: word 14 = 0x80000000, word 15 = 0.
  - Chunk 2: all zero except word 15 = 0x000001C0.
- `chunk_ready` held low for 5 cycles mid-message:
  - `chunk_out` and `chunk_valid` stable throughout.
  - `in_ready`=0 throughout.
  - No word is lost or duplicated after release.
- `rst` pulsed after 7 words, then "abc" -> output identical to the "abc" case: `len`=0x18, `first`=1.
- With `SHA256_PADDER_LEN64_EN` defined, force `len` to 0x1_00000000 before the last word -> word 14 = 0x00000001. Without the macro, word 14 = 0.
